cdc_fifo_rr_arbiter: RTL and testbench



---
 rtl/cdc_fifo_rr_arbiter_pkg.sv | 17 +
 rtl/cdc_fifo_rr_arbiter_rr_pick.sv | 30 +++
 rtl/cdc_fifo_rr_arbiter.sv | 116 +++++++++++
 tb/tb_cdc_fifo_rr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_rr_arbiter_pkg.sv
// Shared types and field layout for the round-robin arbiter in front of cdc_fifo_gray.
// Each beat word is {id, last, data}, and its offsets are given relative to DATA_W.
package cdc_arb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int LAST_BIT_OFS = 0;
   localparam int ID_OFS       = 1;

   function automatic int fields_w(input int data_w, input int id_w);
      return id_w + 1 + data_w;
   endfunction

endpackage

// File: rtl/cdc_fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It returns the first set request found when scanning cyclically from rr_ptr+1.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    grant,
   output logic               grant_valid
);

   logic [NUM_REQ-1:0] rot;
   int                 ofs;
   int                 idx;

   always_comb begin
      // Rotate through a doubled copy so that bit 0 of rot is requester rr_ptr+1.
      rot = NUM_REQ'({req, req} >> (int'(rr_ptr) + 1));
      ofs = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) ofs = k;
      end
      idx = int'(rr_ptr) + 1 + ofs;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      grant_valid = |rot;
      grant       = ID_W'(idx);
   end

endmodule

// File: rtl/cdc_fifo_rr_arbiter.sv
// Shares the source side of one cdc_fifo_gray among NUM_REQ requesters.
// Arbitration is round-robin at packet granularity, and MAX_BURST caps how long one packet holds the lock.
module cdc_fifo_rr_arbiter
   import cdc_arb_pkg::*;
#(
   parameter int  NUM_REQ   = 4,
   parameter int  DATA_W    = 32,
   parameter int  MAX_BURST = 16,
   localparam int ID_W      = $clog2(NUM_REQ),
   localparam int FIFO_W    = fields_w(DATA_W, ID_W)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic                      fifo_valid_o,
   input  logic                      fifo_ready_i,
   output logic [FIFO_W-1:0]         fifo_data_o,
   output logic                      busy_o,
   output logic                      trunc_o
);

   localparam int               CNT_W    = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   pick_idx, grant;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [FIFO_W-1:0] data_d;
   logic              pick_valid, grant_valid, grant_last;
   logic              load_en, accept, valid_d, trunc_d;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req         (req_valid_i),
      .rr_ptr      (rr_ptr_q),
      .grant       (pick_idx),
      .grant_valid (pick_valid)
   );

   assign load_en     = !fifo_valid_o || fifo_ready_i;
   assign grant       = (state_q == LOCKED) ? owner_q : pick_idx;
   assign grant_valid = (state_q == LOCKED) ? req_valid_i[owner_q] : pick_valid;
   assign accept      = load_en && grant_valid;
   assign grant_last  = req_last_i[grant];
   assign valid_d     = load_en ? grant_valid : fifo_valid_o;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[grant] = 1'b1;
   end

   always_comb begin
      data_d                             = '0;
      data_d[DATA_W-1:0]                 = req_data_i[int'(grant)*DATA_W +: DATA_W];
      data_d[DATA_W + LAST_BIT_OFS]      = grant_last;
      data_d[DATA_W + ID_OFS +: ID_W]    = grant;
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path through this block infers a latch.
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      trunc_d    = 1'b0;
      if (accept) begin
         if (state_q == IDLE) begin
            rr_ptr_d = grant;
            if (!grant_last) begin
               state_d    = LOCKED;
               owner_d    = grant;
               beat_cnt_d = CNT_W'(1);
            end
         end else if (grant_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end else if (beat_cnt_q == LAST_CNT) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            trunc_d    = 1'b1;
         end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= ID_W'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
         fifo_valid_o <= 1'b0;
         fifo_data_o  <= '0;
         busy_o       <= 1'b0;
         trunc_o      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         fifo_valid_o <= valid_d;
         busy_o       <= (state_d == LOCKED) || valid_d;
         trunc_o      <= trunc_d;
         if (accept) fifo_data_o <= data_d;
      end
   end

endmodule

// File: tb/tb_cdc_fifo_rr_arbiter.sv
// Scoreboard bench for cdc_fifo_rr_arbiter: expected beats are queued in spec grant order
// and compared against every FIFO-side transfer, alongside per-cycle ready/trunc/busy checks.
module tb_cdc_fifo_rr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 4;
   localparam int ID_W      = 2;
   localparam int FW        = ID_W + 1 + DATA_W;

   localparam logic [3:0] RDY1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   localparam logic [3:0] RDY2 [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
   localparam logic [3:0] RDY3 [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                       4'b1000, 4'b0001, 4'b0001, 4'b0001};
   localparam logic       TRN3 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [3:0] RDY5 [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      int                gap;
   } beat_t;

   logic                      clk_i = 1'b0;
   logic                      rst_ni = 1'b0;
   logic [NUM_REQ-1:0]        req_valid_i = '0;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ*DATA_W-1:0] req_data_i = '0;
   logic [NUM_REQ-1:0]        req_last_i = '0;
   logic                      fifo_valid_o;
   logic                      fifo_ready_i = 1'b1;
   logic [FW-1:0]             fifo_data_o;
   logic                      busy_o;
   logic                      trunc_o;

   beat_t         src_q [NUM_REQ][$];
   int            pause [NUM_REQ];
   logic [FW-1:0] exp_q [$];
   int            n_checks = 0;
   int            n_errors = 0;

   logic [NUM_REQ-1:0] s_ready;
   logic               s_fvalid, s_busy, s_trunc;
   logic [FW-1:0]      s_fdata;

   cdc_fifo_rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_data_i   (req_data_i),
      .req_last_i   (req_last_i),
      .fifo_valid_o (fifo_valid_o),
      .fifo_ready_i (fifo_ready_i),
      .fifo_data_o  (fifo_data_o),
      .busy_o       (busy_o),
      .trunc_o      (trunc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] pack(input int id, input logic last, input logic [DATA_W-1:0] d);
      return {ID_W'(id), last, d};
   endfunction

   task automatic send(input int r, input logic [DATA_W-1:0] d, input logic last, input int gap);
      if (src_q[r].size() == 0) pause[r] = gap;
      src_q[r].push_back('{data: d, last: last, gap: gap});
   endtask

   task automatic sb_push(input int id, input logic [DATA_W-1:0] d, input logic last);
      exp_q.push_back(pack(id, last, d));
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_q[i].size() > 0 && pause[i] == 0) begin
            req_valid_i[i]                 = 1'b1;
            req_last_i[i]                  = src_q[i][0].last;
            req_data_i[i*DATA_W +: DATA_W] = src_q[i][0].data;
         end else begin
            req_valid_i[i]                 = 1'b0;
            req_last_i[i]                  = 1'b0;
            req_data_i[i*DATA_W +: DATA_W] = '0;
         end
      end
   endtask

   // One clock: sample and score at the falling edge, update sources just after the rising edge.
   task automatic step();
      logic [NUM_REQ-1:0] acc;
      @(negedge clk_i);
      s_ready  = req_ready_o;
      s_fvalid = fifo_valid_o;
      s_fdata  = fifo_data_o;
      s_busy   = busy_o;
      s_trunc  = trunc_o;
      if (fifo_valid_o && fifo_ready_i) begin
         if (exp_q.size() == 0) check("extra_beat", 64'(fifo_valid_o), 64'd0);
         else check("fifo_data", 64'(fifo_data_o), 64'(exp_q.pop_front()));
      end
      acc = req_ready_o & req_valid_i;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pause[i] > 0) pause[i]--;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) pause[i] = src_q[i][0].gap;
         end
      end
      drive_inputs();
   endtask

   function automatic bit src_pending();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_q[i].size() > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drain(input string tag);
      int budget = 60;
      while ((exp_q.size() > 0 || src_pending()) && budget > 0) begin
         step();
         budget--;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NUM_REQ; i++) pause[i] = 0;

      // Reset state
      #12;
      check("rst_fifo_valid", 64'(fifo_valid_o), 64'd0);
      check("rst_fifo_data", 64'(fifo_data_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_trunc", 64'(trunc_o), 64'd0);
      check("rst_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;

      // All four requesters send single-beat packets: grants 0,1,2,3,0
      send(0, 32'h100, 1'b1, 0);
      send(0, 32'h104, 1'b1, 0);
      send(1, 32'h101, 1'b1, 0);
      send(2, 32'h102, 1'b1, 0);
      send(3, 32'h103, 1'b1, 0);
      sb_push(0, 32'h100, 1'b1);
      sb_push(1, 32'h101, 1'b1);
      sb_push(2, 32'h102, 1'b1);
      sb_push(3, 32'h103, 1'b1);
      sb_push(0, 32'h104, 1'b1);
      drive_inputs();
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("t1_ready%0d", k), 64'(s_ready), 64'(RDY1[k]));
         if (k < 2) check($sformatf("t1_latency%0d", k), 64'(s_fvalid), 64'(k));
      end
      drain("t1_drain");

      // Req1 three-beat packet holds the grant against req2
      send(1, 32'h200, 1'b0, 0);
      send(1, 32'h201, 1'b0, 0);
      send(1, 32'h202, 1'b1, 0);
      send(2, 32'h210, 1'b1, 0);
      sb_push(1, 32'h200, 1'b0);
      sb_push(1, 32'h201, 1'b0);
      sb_push(1, 32'h202, 1'b1);
      sb_push(2, 32'h210, 1'b1);
      drive_inputs();
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("t2_ready%0d", k), 64'(s_ready), 64'(RDY2[k]));
      end
      drain("t2_drain");

      // MAX_BURST forced release: req3 gets in between req0's bursts
      for (int b = 0; b < 7; b++) begin
         send(0, 32'h300 + 32'(b), (b == 6), 0);
      end
      send(3, 32'h3F0, 1'b1, 2);
      for (int b = 0; b < 4; b++) sb_push(0, 32'h300 + 32'(b), 1'b0);
      sb_push(3, 32'h3F0, 1'b1);
      sb_push(0, 32'h304, 1'b0);
      sb_push(0, 32'h305, 1'b0);
      sb_push(0, 32'h306, 1'b1);
      drive_inputs();
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("t3_ready%0d", k), 64'(s_ready), 64'(RDY3[k]));
         check($sformatf("t3_trunc%0d", k), 64'(s_trunc), 64'(TRN3[k]));
      end
      drain("t3_drain");

      // Back-pressure: output held stable and no accepts while fifo_ready_i is low
      fifo_ready_i = 1'b0;
      send(1, 32'h401, 1'b1, 0);
      send(2, 32'h402, 1'b1, 0);
      send(3, 32'h403, 1'b1, 0);
      sb_push(1, 32'h401, 1'b1);
      sb_push(2, 32'h402, 1'b1);
      sb_push(3, 32'h403, 1'b1);
      drive_inputs();
      step();
      check("t4_first_ready", 64'(s_ready), 64'b0010);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("t4_stall_ready%0d", k), 64'(s_ready), 64'd0);
         check($sformatf("t4_stall_valid%0d", k), 64'(s_fvalid), 64'd1);
         check($sformatf("t4_stall_data%0d", k), 64'(s_fdata), 64'(pack(1, 1'b1, 32'h401)));
      end
      fifo_ready_i = 1'b1;
      drain("t4_drain");

      // Locked owner req2 pauses for three cycles; req0 must wait for the packet end
      send(2, 32'h500, 1'b0, 0);
      send(2, 32'h501, 1'b1, 3);
      send(0, 32'h5A0, 1'b1, 1);
      sb_push(2, 32'h500, 1'b0);
      sb_push(2, 32'h501, 1'b1);
      sb_push(0, 32'h5A0, 1'b1);
      drive_inputs();
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("t5_ready%0d", k), 64'(s_ready), 64'(RDY5[k]));
         if (k >= 1 && k <= 3) check($sformatf("t5_busy%0d", k), 64'(s_busy), 64'd1);
      end
      drain("t5_drain");

      // Asynchronous reset in the middle of a packet
      send(1, 32'h600, 1'b0, 0);
      send(1, 32'h601, 1'b0, 0);
      send(1, 32'h602, 1'b1, 0);
      sb_push(1, 32'h600, 1'b0);
      drive_inputs();
      step();
      step();
      #2;
      check("t6_pre_valid", 64'(fifo_valid_o), 64'd1);
      check("t6_pre_busy", 64'(busy_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_valid", 64'(fifo_valid_o), 64'd0);
      check("t6_rst_busy", 64'(busy_o), 64'd0);
      check("t6_rst_data", 64'(fifo_data_o), 64'd0);
      check("t6_scoreboard", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) begin
         src_q[i].delete();
         pause[i] = 0;
      end
      drive_inputs();
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
      send(3, 32'h6F3, 1'b1, 0);
      send(0, 32'h6F0, 1'b1, 0);
      sb_push(0, 32'h6F0, 1'b1);
      sb_push(3, 32'h6F3, 1'b1);
      drive_inputs();
      step();
      check("t6_post_ready", 64'(s_ready), 64'b0001);
      drain("t6_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
